// File: rtl/gate_vector_checker.sv
// ==== gate_vector_checker: drives all 8 vectors of a 3-input gate, checks F ====
// ==== against EXPECTED after SETTLE cycles per vector.        rev 1.0        ====
`default_nettype none

module gate_vector_checker #(
  parameter logic [7:0] EXPECTED = 8'h45,
  parameter int         SETTLE   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] fail_map,
  output logic [3:0] fail_count
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] idx;
  logic [3:0] cnt;
  logic       miss;

  assign miss = (f != EXPECTED[idx]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 3'd0;
      cnt        <= 4'd0;
      {a, b, c}  <= 3'b000;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_map   <= 8'h00;
      fail_count <= 4'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            idx        <= 3'd0;
            cnt        <= 4'd0;
            {a, b, c}  <= 3'b000;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_map   <= 8'h00;
            fail_count <= 4'd0;
          end
        end
        RUN: begin
          if (cnt == SETTLE_LAST) begin
            cnt <= 4'd0;
            if (miss) begin
              fail_map[idx] <= 1'b1;
              fail_count    <= fail_count + 4'd1;
            end
            // Vector 7's own compare must count toward the verdict at this edge
            if (idx == 3'd7) begin
              state     <= DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              {a, b, c} <= 3'b000;
              pass      <= (fail_count == 4'd0) && !miss;
            end else begin
              idx       <= idx + 3'd1;
              {a, b, c} <= idx + 3'd1;
            end
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
Synthesizable response-side companion to the team's 3-input dataflow gates (F = f(A,B,C)). It drives all 8 input vectors onto a gate under test, samples the gate output after a programmable settle time, and compares each sample against an expected truth table. It reports a per-vector mismatch bitmap, a mismatch count and a pass/fail verdict. It is used as an on-chip self-test and as a reusable checker in gate benches.

Parameters:
EXPECTED, 8'h45, expected truth table; bit k = required F for vector k = {A,B,C}. 8'h45 encodes F = !C && (!A || B).
SETTLE, 1, cycles each vector is held before sampling; legal range 1..15.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  synchronous active-low reset
start  input  1  request a test run; level-sampled, effective only when not busy
a  output  1  gate input A (vector bit 2)
b  output  1  gate input B (vector bit 1)
c  output  1  gate input C (vector bit 0)
f  input  1  gate output under test
busy  output  1  run in progress
done  output  1  run complete; held until next start or reset
pass  output  1  valid while done=1: 1 = no mismatches
fail_map  output  8  bit k set = vector k mismatched
fail_count  output  4  number of mismatching vectors, 0..8

Behaviour:
- Reset (rst_n=0 at an edge): state IDLE. a=b=c=0, busy=0, done=0, pass=0, fail_map=0, fail_count=0, vector index=0, settle counter=0. Reset takes priority over every other event, including mid-run. A run interrupted by reset is abandoned and never reports.
- States: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at edge T0:
  - state becomes RUN, busy=1, done=0, pass=0.
  - fail_map and fail_count clear to 0.
  - index becomes 0 and {a,b,c} becomes 3'b000.
- RUN, start=1: ignored. It has no effect on timing or results.
- Vector k (0..7) is driven on {a,b,c} from edge T0+k*(SETTLE+1) up to edge T0+(k+1)*(SETTLE+1). That is exactly SETTLE+1 cycles per vector.
- Sampling happens at edge T0+(k+1)*(SETTLE+1):
  - f is compared with EXPECTED[k].
  - On mismatch: fail_map[k] is set and fail_count increments.
  - At the same edge, for k<7, {a,b,c} advances to vector k+1.
- Last vector (k=7): at its sampling edge, the state becomes DONE.
  - busy=0, done=1, {a,b,c}=3'b000.
  - pass = 1 only if there was no mismatch on vectors 0..7, including vector 7's compare at this same edge.
- Latency: done rises at edge T0+8*(SETTLE+1). This is 16 cycles with SETTLE=1.
- DONE state:
  - All results hold stable indefinitely.
  - start=1 restarts a run as from IDLE; results clear at that edge.
- Settle counter: 4 bits. It counts 0..SETTLE within each vector, then wraps to 0 on advance. There is no overflow for legal SETTLE values.
- fail_count saturates only by construction; the maximum is 8.
- f is treated as synchronous to clk. Combinational or registered gates are covered by choosing SETTLE ≥ the gate's pipeline depth.
- All outputs are registered. There are no combinational paths from inputs to outputs.

Test Plan:
1. Gate F=!C&&(!A||B) connected, SETTLE=1, start pulsed one cycle:
   - vectors 000..111 appear on a,b,c for 2 cycles each;
   - done=1 exactly 16 cycles after the start edge;
   - pass=1, fail_map=8'h00, fail_count=0, busy=0.
2. f tied to 0 → done after 16 cycles with fail_map=8'h45, fail_count=3, pass=0.
3. f driven as the inverted gate output → fail_map=8'hFF, fail_count=8, pass=0.
4. Start held high for the whole run, plus extra pulses at cycles 5 and 9 → identical timing and results to scenario 1. On a second start while in DONE, the next edge shows done=0, fail_map=0, busy=1, {a,b,c}=000.
5. rst_n=0 for one cycle while vector 4 (100) is driven:
   - next edge: a=b=c=0, busy=0, done=0, fail_map=0, fail_count=0;
   - a subsequent start gives a clean 16-cycle pass run.
6. SETTLE=3 with the gate followed by 2 register stages:
   - each vector is held 4 cycles;
   - done comes 32 cycles after start;
   - pass=1, fail_count=0.
